// File: rtl/ro_meas_ctrl_pkg.sv
// rtl/ro_meas_ctrl_pkg.sv - shared types and default sizes for the ring-oscillator measurement controller
package ro_ctrl_pkg;

    localparam int DEF_GATE_W     = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } ro_state_t;

endpackage

// File: rtl/ro_meas_ctrl_if.sv
// rtl/ro_meas_ctrl_if.sv - control/result bundle between tile pins, oscillator and the measurement controller
interface ro_meas_ctrl_if
    import ro_ctrl_pkg::*;
#(
    parameter int GATE_W = DEF_GATE_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              start;
    logic              abort;
    logic              cont;
    logic [GATE_W-1:0] gate_len;
    logic              osc_in;
    logic              osc_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, abort, cont, gate_len, osc_in,
        input  osc_en, busy, done, count, overflow
    );

    modport slave (
        input  start, abort, cont, gate_len, osc_in,
        output osc_en, busy, done, count, overflow
    );
endinterface

// File: rtl/ro_meas_ctrl_sync_edge.sv
// rtl/ro_meas_ctrl_sync_edge.sv - 2-FF synchronizer with registered rising-edge detect
module ro_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);
    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d_async;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
endmodule

// File: rtl/ro_meas_ctrl.sv
// rtl/ro_meas_ctrl.sv - enables the ring oscillator, settles, counts its edges over a gate window and reports the result
module ro_meas_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int GATE_W     = DEF_GATE_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic           clk,
    input  logic           rst,
    ro_meas_ctrl_if.slave  bus
);
    // One down-counter serves both the settle interval and the gate window.
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int DW = (GATE_W > SW) ? GATE_W : SW;
    localparam logic [DW-1:0] SETTLE_LOAD = DW'(SETTLE_CYC - 1);

    ro_state_t         state, state_nxt;
    logic [DW-1:0]     cnt, cnt_nxt;
    logic [GATE_W-1:0] gate_q, gate_nxt;
    logic [CNT_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]  count_q;
    logic              ovf, ovf_nxt;
    logic              ovf_q;
    logic              load_res;
    logic              rise;

    ro_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (bus.osc_in),
        .rise    (rise)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gate_nxt  = gate_q;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        load_res  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    gate_nxt  = bus.gate_len;
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = SETTLE_LOAD;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    if (gate_q == '0) begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                    end else begin
                        cnt_nxt   = DW'(gate_q) - DW'(1);
                        state_nxt = GATE;
                    end
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            GATE: begin
                // Saturate rather than wrap; an edge lost at all-ones flags overflow.
                if (rise) begin
                    if (&acc) ovf_nxt = 1'b1;
                    else      acc_nxt = acc + CNT_W'(1);
                end
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                end else begin
                    cnt_nxt = cnt - DW'(1);
                end
            end
            DONE: begin
                if (bus.cont) begin
                    gate_nxt  = bus.gate_len;
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = SETTLE_LOAD;
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are latched on entry to DONE so they coincide with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gate_q  <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gate_q <= gate_nxt;
            acc    <= acc_nxt;
            ovf    <= ovf_nxt;
            if (load_res) begin
                count_q <= acc_nxt;
                ovf_q   <= ovf_nxt;
            end
        end
    end

    assign bus.osc_en   = (state == SETTLE) || (state == GATE);
    assign bus.busy     = (state == SETTLE) || (state == GATE);
    assign bus.done     = (state == DONE);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb/tb_ro_meas_ctrl.sv - scoreboard bench for ro_meas_ctrl with a randomized oscillator period and gate length
`timescale 1ns/1ps
module tb_ro_meas_ctrl;
    localparam int GW   = 10;
    localparam int CW   = 5;
    localparam int SC   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        int cyc;
        int lo;
        int hi;
        int ovf_mode;
    } exp_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   osc_half = 20;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_count = 0;
    int   last_ovf = 0;
    exp_t exp_q[$];
    win_t win_q[$];

    ro_meas_ctrl_if #(.GATE_W(GW), .CNT_W(CW)) bus ();

    ro_meas_ctrl #(.GATE_W(GW), .CNT_W(CW), .SETTLE_CYC(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Oscillator edges land at 3 or 8 ns modulo the 10 ns clock, never on a rising clock edge.
    initial begin
        bus.osc_in = 1'b0;
        #3;
        forever begin
            #(osc_half);
            bus.osc_in = ~bus.osc_in;
        end
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input int done_cyc, input int g, input int p);
        exp_t e;
        int lo, hi;
        e.cyc = done_cyc;
        if (g == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            lo = g / p - 1;
            hi = (g + p - 1) / p + 1;
            if (lo < 0) lo = 0;
        end
        e.ovf_mode = (lo > MAXC) ? 1 : ((hi <= MAXC) ? 0 : 2);
        e.lo = (lo > MAXC) ? MAXC : lo;
        e.hi = (hi > MAXC) ? MAXC : hi;
        return e;
    endfunction

    bit   en_exp;
    exp_t e_pop;
    always @(negedge clk) begin
        en_exp = 1'b0;
        foreach (win_q[i])
            if (cyc >= win_q[i].lo && cyc <= win_q[i].hi) en_exp = 1'b1;
        chk(bus.osc_en === en_exp, "osc_en", int'(bus.osc_en), int'(en_exp));
        chk(bus.busy === en_exp, "busy", int'(bus.busy), int'(en_exp));
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected done", 1, 0);
            end else begin
                e_pop = exp_q.pop_front();
                chk(cyc == e_pop.cyc, "done cycle", cyc, e_pop.cyc);
                chk(int'(bus.count) >= e_pop.lo && int'(bus.count) <= e_pop.hi,
                    $sformatf("count in [%0d,%0d]", e_pop.lo, e_pop.hi), int'(bus.count), e_pop.lo);
                if (e_pop.ovf_mode < 2)
                    chk(int'(bus.overflow) == e_pop.ovf_mode, "overflow", int'(bus.overflow), e_pop.ovf_mode);
                else
                    chk(!bus.overflow || int'(bus.count) == MAXC, "overflow implies saturated count",
                        int'(bus.count), MAXC);
                last_count = int'(bus.count);
                last_ovf   = int'(bus.overflow);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            chk(1'b0, "missing done", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk(1'b0, "done timeout", n, 5000);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic measure(input int g, input int p, input bit do_cont, input int nper);
        int c, pd;
        win_t w;
        osc_half = p * 5;
        repeat (8) @(negedge clk);
        pd = SC + g + 1;
        c  = cyc;
        bus.gate_len = GW'(g);
        bus.cont     = do_cont;
        bus.start    = 1'b1;
        for (int k = 0; k < nper; k++) begin
            w.lo = c + 1 + k * pd;
            w.hi = c + k * pd + SC + g;
            win_q.push_back(w);
            exp_q.push_back(mk_exp(c + (k + 1) * pd, g, p));
        end
        @(negedge clk);
        bus.start = 1'b0;
        if (do_cont) begin
            while (cyc < c + (nper - 1) * pd + 1) @(negedge clk);
            bus.cont = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int c, k;
        win_t w;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.cont     = 1'b0;
        bus.gate_len = '0;

        repeat (3) @(negedge clk);
        chk(bus.done == 1'b0, "reset done", int'(bus.done), 0);
        chk(bus.count == '0, "reset count", int'(bus.count), 0);
        chk(bus.overflow == 1'b0, "reset overflow", int'(bus.overflow), 0);
        rst = 1'b0;

        measure(100, 4, 1'b0, 1);
        measure(200, 4, 1'b0, 1);
        measure(20, 4, 1'b0, 1);
        measure(0, 5, 1'b0, 1);

        // Abort at the 10th gate cycle, with an ignored start earlier in the gate.
        repeat (8) @(negedge clk);
        c = cyc;
        bus.gate_len = GW'(100);
        bus.start = 1'b1;
        w.lo = c + 1;
        w.hi = c + 100000;
        win_q.push_back(w);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c + SC + 5) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c + SC + 10) @(negedge clk);
        bus.abort = 1'b1;
        win_q[win_q.size() - 1].hi = cyc;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (4) @(negedge clk);
        chk(int'(bus.count) == last_count, "count held after abort", int'(bus.count), last_count);
        chk(int'(bus.overflow) == last_ovf, "overflow held after abort", int'(bus.overflow), last_ovf);

        // Reset in the middle of the gate window.
        repeat (4) @(negedge clk);
        c = cyc;
        bus.gate_len = GW'(200);
        bus.start = 1'b1;
        w.lo = c + 1;
        w.hi = c + 100000;
        win_q.push_back(w);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c + SC + 30) @(negedge clk);
        rst = 1'b1;
        k = cyc;
        win_q[win_q.size() - 1].hi = k;
        @(negedge clk);
        chk(bus.done == 1'b0, "done after reset", int'(bus.done), 0);
        chk(bus.count == '0, "count after reset", int'(bus.count), 0);
        chk(bus.overflow == 1'b0, "overflow after reset", int'(bus.overflow), 0);
        last_count = 0;
        last_ovf   = 0;
        rst = 1'b0;
        measure(60, 5, 1'b0, 1);

        measure(50, 4, 1'b1, 3);

        for (int i = 0; i < 6; i++)
            measure(int'($urandom_range(0, 300)), int'($urandom_range(4, 6)), 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Measurement controller for the ring-oscillator macro. It enables the oscillator on request, waits a settle interval, then counts oscillator rising edges over a programmable gate window of system clocks and reports the count. It sits between the tile's input pins and the oscillator: it drives the oscillator enable and consumes the oscillator output, which arrives pre-divided so its frequency is below clk/2.

## Interface
Parameters:
- `GATE_W`, default 16: width of the gate-length field, in clock cycles.
- `CNT_W`, default 16: width of the edge counter.
- `SETTLE_CYC`, default 16: number of settle cycles after enable, before gating. Must be ≥ 3 to flush the synchronizer.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level, sampled only in IDLE; begins a measurement.
- `abort` input 1: cancels any measurement in progress.
- `cont` input 1: continuous mode; auto-restart after each result.
- `gate_len` input GATE_W: gate window length in clocks, captured on accepted start.
- `osc_in` input 1: divided oscillator output, asynchronous to clk.
- `osc_en` output 1: oscillator enable.
- `busy` output 1: high in SETTLE and GATE.
- `done` output 1: one-cycle pulse when the result is valid.
- `count` output CNT_W: last completed edge count, held until the next done.
- `overflow` output 1: count saturated during the last completed measurement.

## Operation
- States: IDLE, SETTLE, GATE, DONE.
- IDLE: `osc_en`=0. If `start`=1, capture `gate_len` into `gate_q`, clear the edge accumulator and the internal overflow flag, and go to SETTLE.
- SETTLE: `osc_en`=1. A cycle counter runs SETTLE_CYC cycles. Edges are ignored.
  - After the last settle cycle, go to GATE.
  - If `gate_q`==0, go straight to DONE with count 0.
- GATE: `osc_en`=1. For each cycle with a synchronized rising edge of `osc_in`, increment the accumulator.
  - At all-ones the accumulator saturates and sets the internal overflow flag.
  - The gate counter runs `gate_q` cycles, then the block goes to DONE.
- DONE (one cycle): `osc_en`=0, `done`=1. `count` and `overflow` are loaded from the accumulator and flag in this cycle, so they are visible in the same cycle as `done`.
  - Next state is SETTLE if `cont`=1: `gate_len` is recaptured, and the accumulator and flag are cleared.
  - Otherwise next state is IDLE.
- `abort`=1 in SETTLE or GATE: next state is IDLE, `osc_en` drops the next cycle, no `done` pulse, `count` and `overflow` unchanged. `abort` has priority over both the gate-end and settle-end transitions. `abort` in IDLE or DONE has no effect; DONE still completes.
- `start` outside IDLE is ignored, and is not queued.
- `rst`: state goes to IDLE; `osc_en`, `busy`, `done`, `count` and `overflow` all go to 0; the synchronizer flops and the accumulator are cleared. Reset mid-measurement discards the measurement.
- Edge detection: a 2-FF synchronizer followed by a registered previous-value compare. A rising edge means sync=1 while prev=0.

## Timing
- `start` accepted at cycle t:
  - SETTLE covers t+1 … t+SETTLE_CYC.
  - GATE covers t+SETTLE_CYC+1 … t+SETTLE_CYC+gate_len.
  - `done` is high at t+SETTLE_CYC+gate_len+1.
- `osc_en` is high from t+1 through the last GATE cycle.
- `busy` equals (state ∈ {SETTLE, GATE}); it is low in the `done` cycle.
- Edge-to-count latency is 3 clocks (2 synchronizer stages plus the detect stage). Edges entering the synchronizer in the last 3 GATE cycles are not counted, and edges from SETTLE are never counted. Accuracy is ±1 of the ideal count gate_len·f_osc/f_clk.
- Continuous mode: measurement period is SETTLE_CYC+gate_len+1 clocks, and `osc_en` is low for exactly one cycle in each period.

## Structure
- Package `ro_ctrl_pkg` holds:
  - the state enum `ro_state_t` {IDLE, SETTLE, GATE, DONE};
  - default localparams for GATE_W, CNT_W and SETTLE_CYC.
- Sub-module `ro_sync_edge`: 2-FF synchronizer plus rising-edge detector.
  - Ports: `clk`, `rst`, `d_async`, `rise`.
  - Reset clears all of its flops.
- Top level holds the FSM, the settle/gate down-counter (shared between the two states), the saturating accumulator and the result registers.

## Test plan
- Basic measurement: SETTLE_CYC=4, osc period = 4 clocks, `start` pulse with gate_len=100 → `done` at t+105, `count` ∈ {24, 25, 26}, `overflow`=0, `osc_en` high for cycles t+1…t+104.
- Saturation: CNT_W=4, osc period = 4 clocks, gate_len=100 → `count`=15, `overflow`=1. A following run with gate_len=20 → `count` ∈ {4, 5, 6}, `overflow`=0.
- Zero gate: gate_len=0 → `done` at t+SETTLE_CYC+1, `count`=0, `overflow`=0, no GATE cycles.
- Abort: assert `abort` at the 10th GATE cycle → `osc_en`=0 and `busy`=0 the next cycle, no `done`, previous `count` held. A `start` issued during GATE is ignored.
- Reset mid-GATE: assert `rst` → next cycle all outputs are 0 and state is IDLE. A fresh `start` then produces a correct result.
- Continuous mode: `cont`=1, gate_len=50 → `done` pulses exactly every SETTLE_CYC+51 clocks, and `osc_en` is low only in each `done` cycle.
